tdc_meas_ctrl: RTL

//  Measurement sequencer for one TDC channel, sitting between the start/readout logic and the stop-filter.
//  - Opens the hit window (hit_en gates the raw hit into the stop-filter).
//  - Runs the coarse clock counter and timestamps the first filtered stop (hit_valid) with coarse count + fine code.
//  - Terminates on hit or timeout, presents a result over a valid/ready handshake, then enforces a dead time.

---
 rtl/tdc_meas_ctrl_pkg.sv | 15 +
 rtl/tdc_meas_ctrl_coarse_counter.sv | 29 ++
 rtl/tdc_meas_ctrl.sv | 128 ++++++++++++
 3 files changed

// File: rtl/tdc_meas_ctrl_pkg.sv
// Shared definitions for the TDC measurement sequencer: FSM state encoding and default widths.
package tdc_meas_ctrl_pkg;

    localparam int COARSE_W_DEF = 16;
    localparam int FINE_W_DEF   = 8;
    localparam int STAT_W       = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_RESULT = 2'd2,
        ST_DEAD   = 2'd3
    } state_t;

endpackage

// File: rtl/tdc_meas_ctrl_coarse_counter.sv
// Coarse clock counter for one measurement window: cleared while idle, counts while enabled,
// and stops on the terminal count TIMEOUT_CYC-1 so it never wraps inside a window.
module tdc_coarse_counter #(
    parameter int COARSE_W    = 16,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                en,
    output logic [COARSE_W-1:0] count,
    output logic                tc
);

    localparam logic [COARSE_W-1:0] TC_VAL = COARSE_W'(TIMEOUT_CYC - 1);

    assign tc = (count == TC_VAL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && !tc) begin
            count <= count + COARSE_W'(1);
        end
    end

endmodule

// File: rtl/tdc_meas_ctrl.sv
// Measurement sequencer for one TDC channel: hit window, timestamp capture, result handshake, dead time.
// Optional statistics counters are built only when TDC_MEAS_CTRL_STATS_EN is defined.
module tdc_meas_ctrl
    import tdc_meas_ctrl_pkg::*;
#(
    parameter int COARSE_W     = COARSE_W_DEF,
    parameter int FINE_W       = FINE_W_DEF,
    parameter int TIMEOUT_CYC  = 256,
    parameter int DEADTIME_CYC = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                hit_valid,
    input  logic [FINE_W-1:0]   fine_code,
    output logic                hit_en,
    output logic                busy,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [COARSE_W-1:0] res_coarse,
    output logic [FINE_W-1:0]   res_fine,
    output logic                res_timeout,
    output logic [STAT_W-1:0]   stat_hits,
    output logic [STAT_W-1:0]   stat_tmo
);

    localparam int DEAD_LAST = (DEADTIME_CYC > 0) ? DEADTIME_CYC - 1 : 0;
    localparam int DEAD_W    = (DEAD_LAST > 0) ? $clog2(DEAD_LAST + 1) : 1;

    state_t              state;
    state_t              state_nxt;
    logic [COARSE_W-1:0] coarse;
    logic                coarse_tc;
    logic [DEAD_W-1:0]   dead_cnt;
    logic                hit_term;
    logic                tmo_term;

    // A hit on the terminal cycle still counts as a hit.
    assign hit_term = (state == ST_WAIT) && hit_valid;
    assign tmo_term = (state == ST_WAIT) && !hit_valid && coarse_tc;

    tdc_coarse_counter #(
        .COARSE_W    (COARSE_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_coarse (
        .clk   (clk),
        .rst   (rst),
        .clr   (state == ST_IDLE),
        .en    (state == ST_WAIT),
        .count (coarse),
        .tc    (coarse_tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (start) state_nxt = ST_WAIT;
            ST_WAIT:   if (hit_term || tmo_term) state_nxt = ST_RESULT;
            ST_RESULT: if (res_ready) state_nxt = (DEADTIME_CYC == 0) ? ST_IDLE : ST_DEAD;
            ST_DEAD:   if (dead_cnt == DEAD_W'(DEAD_LAST)) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        hit_en    = (state == ST_WAIT);
        busy      = (state != ST_IDLE);
        res_valid = (state == ST_RESULT);
    end

    // Dead-time counter runs from 0 in the first DEAD cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dead_cnt <= '0;
        end else if (state != ST_DEAD) begin
            dead_cnt <= '0;
        end else begin
            dead_cnt <= dead_cnt + DEAD_W'(1);
        end
    end

    // Result registers only load on the WAIT exit, so they hold through backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_coarse  <= '0;
            res_fine    <= '0;
            res_timeout <= 1'b0;
        end else if (hit_term || tmo_term) begin
            res_coarse  <= coarse;
            res_fine    <= hit_term ? fine_code : '0;
            res_timeout <= tmo_term;
        end
    end

`ifdef TDC_MEAS_CTRL_STATS_EN
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == {STAT_W{1'b1}}) ? v : v + STAT_W'(1);
    endfunction

    logic [STAT_W-1:0] stat_hits_q;
    logic [STAT_W-1:0] stat_tmo_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_hits_q <= '0;
            stat_tmo_q  <= '0;
        end else begin
            if (hit_term) stat_hits_q <= sat_inc(stat_hits_q);
            if (tmo_term) stat_tmo_q  <= sat_inc(stat_tmo_q);
        end
    end

    assign stat_hits = stat_hits_q;
    assign stat_tmo  = stat_tmo_q;
`else
    assign stat_hits = '0;
    assign stat_tmo  = '0;
`endif

endmodule
